// File: rtl/playback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : playback_ctrl
//  Description : Playback sequencer for the audio player. It selects the
//                track (next/previous buttons), pauses and resumes, handles
//                end-of-track and requests track loads from the datapath
//                with a req/ack handshake. It also keeps the mm:ss elapsed
//                time and drives four active-low 7-segment displays.
//  Options     : PLAYBACK_AUTONEXT_EN - when defined, end of track advances
//                to the next track; otherwise playback stops on the final
//                time until the user acts.
//  Revision    : 1.0 - initial release
// ============================================================================
module playback_ctrl #(
    parameter int NUM_TRACKS      = 8,
    parameter int TRACK_W         = 3,
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int RESTART_SEC     = 3
) (
    input  logic               clk_clk,
    input  logic               rst_export,
    input  logic               siguiente_btn_export,
    input  logic               anterior_btn_export,
    input  logic               pausa_sw_export,
    output logic               load_req,
    input  logic               load_ack,
    input  logic               track_done,
    output logic [TRACK_W-1:0] track_idx,
    output logic               play_en,
    output logic [6:0]         min1_export,
    output logic [6:0]         min2_export,
    output logic [6:0]         seg1_export,
    output logic [6:0]         seg2_export
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int C_PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int C_DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [C_PRESC_W-1:0] C_PRESC_MAX = C_PRESC_W'(CLK_HZ - 1);
    localparam logic [C_DB_W-1:0]    C_DB_MAX    = C_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TRACK_W-1:0]   C_LAST_IDX  = TRACK_W'(NUM_TRACKS - 1);

    // Seconds-within-minute never reach 60, so a larger threshold is only
    // met once a minute has elapsed.
    localparam int         C_RESTART_CLAMP = (RESTART_SEC > 60) ? 60 : RESTART_SEC;
    localparam logic [6:0] C_RESTART_LIM   = 7'(C_RESTART_CLAMP);

    localparam logic [6:0] C_SEG_ZERO = 7'b1000000;

    // Bit positions inside the synchronizer vectors
    localparam int C_NXT = 0;
    localparam int C_PRV = 1;
    localparam int C_PAU = 2;

    // Sequencer states
    localparam logic [1:0] C_ST_LOAD  = 2'd0;  // load request outstanding
    localparam logic [1:0] C_ST_PLAY  = 2'd1;  // streaming, time running
    localparam logic [1:0] C_ST_PAUSE = 2'd2;  // user pause
    localparam logic [1:0] C_ST_DONE  = 2'd3;  // stopped at end of track

    // ------------------------------------------------------------------------
    // BCD digit to active-low 7-segment pattern (bit6..0 = g..a)
    // ------------------------------------------------------------------------
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [2:0]             sync1_q, sync2_q;
    logic                   pausa_prev_q, pausa_prev_d;

    logic [1:0][C_DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]             db_lvl_q, db_lvl_d;
    logic [1:0]             btn_p_q, btn_p_d;

    logic [1:0]             state_q, state_d;
    logic [TRACK_W-1:0]     idx_q, idx_d;
    logic                   load_req_q, load_req_d;
    logic                   play_en_q, play_en_d;

    logic [C_PRESC_W-1:0]   presc_q, presc_d;
    logic [3:0]             sec_lo_q, sec_lo_d;
    logic [2:0]             sec_hi_q, sec_hi_d;
    logic [3:0]             min_lo_q, min_lo_d;
    logic [3:0]             min_hi_q, min_hi_d;

    logic [6:0]             min1_q, min1_d;
    logic [6:0]             min2_q, min2_d;
    logic [6:0]             seg1_q, seg1_d;
    logic [6:0]             seg2_q, seg2_d;

    logic                   w_nxt_p, w_prv_p;
    logic                   w_pausa;
    logic                   w_pausa_fall;
    logic                   w_restart;
    logic                   w_at_restart;
    logic [6:0]             w_sec_bin;
    logic [TRACK_W-1:0]     w_idx_inc, w_idx_dec;

    // ------------------------------------------------------------------------
    // Input synchronizers (two flops per asynchronous input); buttons idle high
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (rst_export) begin
            sync1_q <= 3'b011;
            sync2_q <= 3'b011;
        end else begin
            sync1_q <= {pausa_sw_export, anterior_btn_export, siguiente_btn_export};
            sync2_q <= sync1_q;
        end
    end

    assign w_pausa      = sync2_q[C_PAU];
    assign w_pausa_fall = pausa_prev_q & ~w_pausa;
    assign pausa_prev_d = w_pausa;

    // Debounce: a level is accepted after DEBOUNCE_CYCLES consecutive differing
    // samples; a falling debounced level produces a one-cycle press pulse.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            db_lvl_d[i] = db_lvl_q[i];
            if (sync2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == C_DB_MAX) begin
                    db_lvl_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
            btn_p_d[i] = db_lvl_q[i] & ~db_lvl_d[i];
        end
    end

    // Debounce state, press pulses and pause edge history
    always_ff @(posedge clk_clk) begin
        if (rst_export) begin
            db_cnt_q     <= '0;
            db_lvl_q     <= 2'b11;
            btn_p_q      <= 2'b00;
            pausa_prev_q <= 1'b0;
        end else begin
            db_cnt_q     <= db_cnt_d;
            db_lvl_q     <= db_lvl_d;
            btn_p_q      <= btn_p_d;
            pausa_prev_q <= pausa_prev_d;
        end
    end

    assign w_nxt_p = btn_p_q[C_NXT];
    assign w_prv_p = btn_p_q[C_PRV];

    // ------------------------------------------------------------------------
    // Track index helpers and restart threshold
    // ------------------------------------------------------------------------
    assign w_idx_inc    = (idx_q == C_LAST_IDX) ? '0 : idx_q + 1'b1;
    assign w_idx_dec    = (idx_q == '0) ? C_LAST_IDX : idx_q - 1'b1;
    assign w_sec_bin    = ({4'd0, sec_hi_q} * 7'd10) + {3'd0, sec_lo_q};
    assign w_at_restart = (min_hi_q != 4'd0) || (min_lo_q != 4'd0) ||
                          (w_sec_bin >= C_RESTART_LIM);

    // ------------------------------------------------------------------------
    // Sequencer state register and registered handshake outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_clk) begin
        if (rst_export) begin
            state_q    <= C_ST_LOAD;
            idx_q      <= '0;
            load_req_q <= 1'b0;
            play_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            load_req_q <= load_req_d;
            play_en_q  <= play_en_d;
        end
    end

    // Next state: buttons beat end-of-track, next beats previous
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        w_restart = 1'b0;
        case (state_q)
            C_ST_LOAD: begin
                if (load_ack) begin
                    state_d = w_pausa ? C_ST_PAUSE : C_ST_PLAY;
                end
            end
            default: begin
                if (w_nxt_p) begin
                    idx_d     = w_idx_inc;
                    state_d   = C_ST_LOAD;
                    w_restart = 1'b1;
                end else if (w_prv_p) begin
                    idx_d     = w_at_restart ? idx_q : w_idx_dec;
                    state_d   = C_ST_LOAD;
                    w_restart = 1'b1;
                end else if ((state_q == C_ST_PLAY) && track_done) begin
`ifdef PLAYBACK_AUTONEXT_EN
                    idx_d     = w_idx_inc;
                    state_d   = C_ST_LOAD;
                    w_restart = 1'b1;
`else
                    state_d   = C_ST_DONE;
`endif
                end else if (state_q == C_ST_DONE) begin
                    // Releasing pause after end of track replays the same track
                    if (w_pausa_fall) begin
                        state_d   = C_ST_LOAD;
                        w_restart = 1'b1;
                    end
                end else if ((state_q == C_ST_PLAY) && w_pausa) begin
                    state_d = C_ST_PAUSE;
                end else if ((state_q == C_ST_PAUSE) && !w_pausa) begin
                    state_d = C_ST_PLAY;
                end
            end
        endcase
    end

    // Outputs decoded from the next state so they align with the state register
    always_comb begin
        load_req_d = (state_d == C_ST_LOAD);
        play_en_d  = (state_d == C_ST_PLAY);
    end

    assign load_req  = load_req_q;
    assign play_en   = play_en_q;
    assign track_idx = idx_q;

    // ------------------------------------------------------------------------
    // Elapsed time: prescaler plus BCD mm:ss, running only while playing
    // ------------------------------------------------------------------------
    always_comb begin
        presc_d  = presc_q;
        sec_lo_d = sec_lo_q;
        sec_hi_d = sec_hi_q;
        min_lo_d = min_lo_q;
        min_hi_d = min_hi_q;
        if (w_restart || (state_q == C_ST_LOAD)) begin
            presc_d  = '0;
            sec_lo_d = 4'd0;
            sec_hi_d = 3'd0;
            min_lo_d = 4'd0;
            min_hi_d = 4'd0;
        end else if (state_q == C_ST_PLAY) begin
            if (presc_q == C_PRESC_MAX) begin
                presc_d = '0;
                if (sec_lo_q == 4'd9) begin
                    sec_lo_d = 4'd0;
                    if (sec_hi_q == 3'd5) begin
                        sec_hi_d = 3'd0;
                        if (min_lo_q == 4'd9) begin
                            min_lo_d = 4'd0;
                            min_hi_d = (min_hi_q == 4'd9) ? 4'd0 : min_hi_q + 4'd1;
                        end else begin
                            min_lo_d = min_lo_q + 4'd1;
                        end
                    end else begin
                        sec_hi_d = sec_hi_q + 3'd1;
                    end
                end else begin
                    sec_lo_d = sec_lo_q + 4'd1;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    // Time registers
    always_ff @(posedge clk_clk) begin
        if (rst_export) begin
            presc_q  <= '0;
            sec_lo_q <= 4'd0;
            sec_hi_q <= 3'd0;
            min_lo_q <= 4'd0;
            min_hi_q <= 4'd0;
        end else begin
            presc_q  <= presc_d;
            sec_lo_q <= sec_lo_d;
            sec_hi_q <= sec_hi_d;
            min_lo_q <= min_lo_d;
            min_hi_q <= min_hi_d;
        end
    end

    // ------------------------------------------------------------------------
    // Display decode, one register stage behind the time registers
    // ------------------------------------------------------------------------
    always_comb begin
        min1_d = seg7(min_hi_q);
        min2_d = seg7(min_lo_q);
        seg1_d = seg7({1'b0, sec_hi_q});
        seg2_d = seg7(sec_lo_q);
    end

    // Display registers
    always_ff @(posedge clk_clk) begin
        if (rst_export) begin
            min1_q <= C_SEG_ZERO;
            min2_q <= C_SEG_ZERO;
            seg1_q <= C_SEG_ZERO;
            seg2_q <= C_SEG_ZERO;
        end else begin
            min1_q <= min1_d;
            min2_q <= min2_d;
            seg1_q <= seg1_d;
            seg2_q <= seg2_d;
        end
    end

    assign min1_export = min1_q;
    assign min2_export = min2_q;
    assign seg1_export = seg1_q;
    assign seg2_export = seg2_q;

endmodule
`default_nettype wire

// File: tb/tb_playback_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_playback_ctrl
//  Description : Scoreboard bench for playback_ctrl. Stimulus pushes the
//                expected track index of every load request and expected
//                output snapshots into queues; a negedge monitor pops and
//                compares. Follows PLAYBACK_AUTONEXT_EN for end-of-track.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_playback_ctrl;

    localparam int NUM_TRACKS = 4;
    localparam int TRACK_W    = 2;

    logic               clk;
    logic               rst;
    logic               sig_n, ant_n, pausa;
    logic               load_req, load_ack, track_done, play_en;
    logic [TRACK_W-1:0] track_idx;
    logic [6:0]         min1, min2, seg1, seg2;

    playback_ctrl #(
        .NUM_TRACKS      (NUM_TRACKS),
        .TRACK_W         (TRACK_W),
        .CLK_HZ          (10),
        .DEBOUNCE_CYCLES (4),
        .RESTART_SEC     (3)
    ) dut (
        .clk_clk              (clk),
        .rst_export           (rst),
        .siguiente_btn_export (sig_n),
        .anterior_btn_export  (ant_n),
        .pausa_sw_export      (pausa),
        .load_req             (load_req),
        .load_ack             (load_ack),
        .track_done           (track_done),
        .track_idx            (track_idx),
        .play_en              (play_en),
        .min1_export          (min1),
        .min2_export          (min2),
        .seg1_export          (seg1),
        .seg2_export          (seg2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] vec;   // {load_req, play_en, idx, min1, min2, seg1, seg2}
    } snap_t;

    snap_t              snap_q[$];
    logic [TRACK_W-1:0] load_q[$];
    int                 total = 0;
    int                 bad   = 0;
    logic               lr_prev = 1'b0;

    // Hand-written active-low digit patterns (g..a)
    function automatic logic [6:0] dig(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic lr, input logic pe,
                                       input int idx, input int mm, input int ss);
        logic [TRACK_W-1:0] i;
        i = TRACK_W'(idx);
        return {lr, pe, i, dig(mm / 10), dig(mm % 10), dig(ss / 10), dig(ss % 10)};
    endfunction

    task automatic expect_snap(input string name, input logic lr, input logic pe,
                               input int idx, input int mm, input int ss);
        snap_t s;
        s.name = name;
        s.vec  = mk(lr, pe, idx, mm, ss);
        snap_q.push_back(s);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        load_ack = 1'b1;
        tick(1);
        load_ack = 1'b0;
    endtask

    // which: 0 = next, 1 = previous, 2 = both
    task automatic press(input int which, input int hold);
        if (which != 1) sig_n = 1'b0;
        if (which != 0) ant_n = 1'b0;
        tick(hold);
        sig_n = 1'b1;
        ant_n = 1'b1;
        tick(10);
    endtask

    // Monitor: checks every rising load_req against the next expected index,
    // and every queued snapshot against the current outputs.
    always @(negedge clk) begin
        logic [31:0] act;
        logic [TRACK_W-1:0] e;
        if (load_req && !lr_prev) begin
            total++;
            if (load_q.size() == 0) begin
                bad++;
                $display("FAIL load_rise: unexpected load request idx=%0d", track_idx);
            end else begin
                e = load_q.pop_front();
                if (track_idx !== e) begin
                    bad++;
                    $display("FAIL load_rise: idx got %0d want %0d", track_idx, e);
                end
            end
        end
        lr_prev = load_req;
        act = {load_req, play_en, track_idx, min1, min2, seg1, seg2};
        while (snap_q.size() > 0) begin
            snap_t s;
            s = snap_q.pop_front();
            total++;
            if (act !== s.vec) begin
                bad++;
                $display("FAIL %s: got %h want %h (lr,pe,idx,m1,m2,s1,s2)", s.name, act, s.vec);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sig_n = 1'b1; ant_n = 1'b1; pausa = 1'b0;
        load_ack = 1'b0; track_done = 1'b0;
        tick(3);
        expect_snap("reset", 1'b0, 1'b0, 0, 0, 0);
        tick(1);

        // Release reset, ack on the fifth cycle
        load_q.push_back(0);
        rst = 1'b0;
        tick(4);
        expect_snap("load_wait", 1'b1, 1'b0, 0, 0, 0);
        ack_pulse();
        expect_snap("after_ack", 1'b0, 1'b1, 0, 0, 0);

        // Elapsed time at CLK_HZ=10
        tick(601);
        expect_snap("time_01_00", 1'b0, 1'b1, 0, 1, 0);
        tick(59390);
        expect_snap("time_99_59", 1'b0, 1'b1, 0, 99, 59);
        tick(10);
        expect_snap("time_wrap", 1'b0, 1'b1, 0, 0, 0);

        // Pause freezes everything
        pausa = 1'b1;
        tick(3);
        expect_snap("pause_enter", 1'b0, 1'b0, 0, 0, 0);
        tick(100);
        expect_snap("pause_frozen", 1'b0, 1'b0, 0, 0, 0);

        // Step to the last track while paused
        for (int i = 1; i < NUM_TRACKS; i++) begin
            load_q.push_back(TRACK_W'(i));
            press(0, 10);
            ack_pulse();
            tick(2);
        end

        // Short glitch is rejected, long press wraps 3 -> 0
        press(0, 3);
        expect_snap("short_press", 1'b0, 1'b0, 3, 0, 0);
        load_q.push_back(0);
        press(0, 10);
        expect_snap("next_wrap", 1'b1, 1'b0, 0, 0, 0);
        ack_pulse();
        tick(2);

        // Resume play and run to 00:05
        pausa = 1'b0;
        tick(3);
        expect_snap("resume", 1'b0, 1'b1, 0, 0, 0);
        tick(56);
        expect_snap("time_00_05", 1'b0, 1'b1, 0, 0, 5);

        // Previous past the threshold restarts the same track
        load_q.push_back(0);
        press(1, 10);
        expect_snap("prev_restart", 1'b1, 1'b0, 0, 0, 0);
        ack_pulse();

        // Previous right away goes back, wrapping 0 -> 3
        load_q.push_back(3);
        press(1, 10);
        expect_snap("prev_wrap", 1'b1, 1'b0, 3, 0, 0);

        // Reset in the middle of a load
        rst = 1'b1;
        tick(2);
        expect_snap("reset_in_load", 1'b0, 1'b0, 0, 0, 0);
        load_q.push_back(0);
        rst = 1'b0;
        tick(4);
        ack_pulse();

        // Both buttons together: next wins
        load_q.push_back(1);
        press(2, 10);
        expect_snap("both_next", 1'b1, 1'b0, 1, 0, 0);
        ack_pulse();

        // End of track at 00:07
        tick(75);
        expect_snap("time_00_07", 1'b0, 1'b1, 1, 0, 7);
`ifdef PLAYBACK_AUTONEXT_EN
        load_q.push_back(2);
`endif
        track_done = 1'b1;
        tick(1);
        track_done = 1'b0;
        tick(2);
`ifdef PLAYBACK_AUTONEXT_EN
        expect_snap("done_autonext", 1'b1, 1'b0, 2, 0, 0);
        ack_pulse();
        tick(3);
        expect_snap("done_play", 1'b0, 1'b1, 2, 0, 0);
`else
        expect_snap("done_stop", 1'b0, 1'b0, 1, 0, 7);
        tick(100);
        expect_snap("done_frozen", 1'b0, 1'b0, 1, 0, 7);
        pausa = 1'b1;
        tick(5);
        load_q.push_back(1);
        pausa = 1'b0;
        tick(10);
        expect_snap("done_replay", 1'b1, 1'b0, 1, 0, 0);
        ack_pulse();
`endif
        tick(5);

        total++;
        if (load_q.size() != 0) begin
            bad++;
            $display("FAIL pending_loads: got %0d outstanding want 0", load_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
